// File: rtl/bidir_dir_arbiter_if.sv
// Handshake bundle between the two requesting agents and the direction arbiter.
// Latency: none (wires only). Backpressure: a requester holds req until it sees
// its grant and stops driving the bus as soon as the grant falls.
// Ports/signals:
//   req_a, req_b  - side A / side B bus requests (from the agents)
//   en_ab, en_ba  - buffer direction enables (from the arbiter)
//   gnt_a, gnt_b  - grants, identical to en_ab / en_ba
//   busy, turn    - bus owned or turning around / dead-bus turnaround only
interface bidir_dir_arbiter_if;
   logic req_a;
   logic req_b;
   logic en_ab;
   logic en_ba;
   logic gnt_a;
   logic gnt_b;
   logic busy;
   logic turn;

   // Requesting side: drives the requests and observes the grants.
   modport master (
      output req_a, req_b,
      input  en_ab, en_ba, gnt_a, gnt_b, busy, turn
   );

   // Arbiter side: observes the requests and drives the enables and grants.
   modport slave (
      input  req_a, req_b,
      output en_ab, en_ba, gnt_a, gnt_b, busy, turn
   );
endinterface

// File: rtl/bidir_dir_arbiter.sv
// Direction arbiter for a shared bidirectional A/B buffer pair.
// Latency: grant 1 cycle after the request is sampled; TURNAROUND dead cycles after any release.
// Backpressure: a waiting side bounds the owner's tenure to MAX_HOLD cycles (0 = unlimited).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; forces every output low at once
//   bus  - slave side of bidir_dir_arbiter_if (req_a/req_b in; enables, grants, busy, turn out)
module bidir_dir_arbiter #(
   parameter int TURNAROUND = 2,
   parameter int MAX_HOLD   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   bidir_dir_arbiter_if.slave   bus
);

   localparam int HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int TURN_W     = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
   localparam int HOLD_LIMIT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam int TURN_LIMIT = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;

   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT);
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_LIMIT);
   localparam logic              HOLD_EN   = (MAX_HOLD != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRV_A = 2'd1,
      DRV_B = 2'd2,
      TURN  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                last_b_q, last_b_d;   // 1: the most recent owner was B
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [TURN_W-1:0]   turn_q, turn_d;
   logic                hold_expired;
   logic [HOLD_W-1:0]   hold_inc;

   // Single grant wins outright; a tie goes to the side that did not own last.
   function automatic state_t pick(input logic ra, input logic rb, input logic last_b);
      state_t s;
      if (ra && rb)
         s = last_b ? DRV_A : DRV_B;
      else if (ra)
         s = DRV_A;
      else if (rb)
         s = DRV_B;
      else
         s = IDLE;
      return s;
   endfunction

   // Using >= rather than == means a waiter that shows up after the count has
   // already saturated still forces a release on its first waiting cycle.
   assign hold_expired = HOLD_EN && (hold_q >= HOLD_LAST);
   assign hold_inc     = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_b_q <= 1'b1;
         hold_q   <= '0;
         turn_q   <= '0;
      end else begin
         state_q  <= state_d;
         last_b_q <= last_b_d;
         hold_q   <= hold_d;
         turn_q   <= turn_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_b_d = last_b_q;
      hold_d   = hold_q;
      turn_d   = turn_q;
      case (state_q)
         IDLE: begin
            state_d = pick(bus.req_a, bus.req_b, last_b_q);
            hold_d  = '0;
         end
         DRV_A: begin
            if (!bus.req_a || (bus.req_b && hold_expired)) begin
               state_d  = TURN;
               last_b_d = 1'b0;
               turn_d   = '0;
            end else begin
               hold_d = hold_inc;
            end
         end
         DRV_B: begin
            if (!bus.req_b || (bus.req_a && hold_expired)) begin
               state_d  = TURN;
               last_b_d = 1'b1;
               turn_d   = '0;
            end else begin
               hold_d = hold_inc;
            end
         end
         TURN: begin
            // Forced and voluntary releases look the same from here on.
            if (turn_q == TURN_LAST) begin
               state_d = pick(bus.req_a, bus.req_b, last_b_q);
               hold_d  = '0;
            end else begin
               turn_d = turn_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode the state register alone, so reset clears them immediately
   // and the two enables can never be high together.
   assign bus.en_ab = (state_q == DRV_A);
   assign bus.en_ba = (state_q == DRV_B);
   assign bus.gnt_a = (state_q == DRV_A);
   assign bus.gnt_b = (state_q == DRV_B);
   assign bus.busy  = (state_q != IDLE);
   assign bus.turn  = (state_q == TURN);

endmodule

// File: tb/tb_bidir_dir_arbiter.sv
// Bench for bidir_dir_arbiter: directed request vectors with expected output
// codes queued per cycle, popped and compared by an independent monitor;
// random-request phase checks the exclusion and busy invariants.
module tb_bidir_dir_arbiter;

   localparam int C_I = 0;   // idle
   localparam int C_A = 1;   // A owns the bus
   localparam int C_B = 2;   // B owns the bus
   localparam int C_T = 3;   // turnaround

   typedef struct {
      int         sel;
      logic [5:0] exp;
      int         idx;
   } sb_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   vec_n;
   sb_t  sb_q[$];

   bidir_dir_arbiter_if ifm ();   // TURNAROUND 2, MAX_HOLD 4
   bidir_dir_arbiter_if ifu ();   // TURNAROUND 2, MAX_HOLD 0
   bidir_dir_arbiter_if if1 ();   // TURNAROUND 1, MAX_HOLD 4
   bidir_dir_arbiter_if if3 ();   // TURNAROUND 3, MAX_HOLD 4

   bidir_dir_arbiter #(.TURNAROUND(2), .MAX_HOLD(4)) dut_m (.clk(clk), .rst(rst), .bus(ifm.slave));
   bidir_dir_arbiter #(.TURNAROUND(2), .MAX_HOLD(0)) dut_u (.clk(clk), .rst(rst), .bus(ifu.slave));
   bidir_dir_arbiter #(.TURNAROUND(1), .MAX_HOLD(4)) dut_1 (.clk(clk), .rst(rst), .bus(if1.slave));
   bidir_dir_arbiter #(.TURNAROUND(3), .MAX_HOLD(4)) dut_3 (.clk(clk), .rst(rst), .bus(if3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {en_ab, en_ba, gnt_a, gnt_b, busy, turn}
   function automatic logic [5:0] code_vec(input int code);
      logic [5:0] v;
      case (code)
         C_A:     v = 6'b101010;
         C_B:     v = 6'b010110;
         C_T:     v = 6'b000011;
         default: v = 6'b000000;
      endcase
      return v;
   endfunction

   function automatic logic [5:0] got_vec(input int sel);
      logic [5:0] v;
      case (sel)
         0:       v = {ifm.en_ab, ifm.en_ba, ifm.gnt_a, ifm.gnt_b, ifm.busy, ifm.turn};
         1:       v = {ifu.en_ab, ifu.en_ba, ifu.gnt_a, ifu.gnt_b, ifu.busy, ifu.turn};
         2:       v = {if1.en_ab, if1.en_ba, if1.gnt_a, if1.gnt_b, if1.busy, if1.turn};
         default: v = {if3.en_ab, if3.en_ba, if3.gnt_a, if3.gnt_b, if3.busy, if3.turn};
      endcase
      return v;
   endfunction

   // Drive one cycle of requests on the chosen DUT and queue the expected
   // outputs that must appear after the following rising edge.
   task automatic step(input int sel, input logic ra, input logic rb, input int code);
      sb_t e;
      @(negedge clk);
      case (sel)
         0:       begin ifm.req_a = ra; ifm.req_b = rb; end
         1:       begin ifu.req_a = ra; ifu.req_b = rb; end
         2:       begin if1.req_a = ra; if1.req_b = rb; end
         default: begin if3.req_a = ra; if3.req_b = rb; end
      endcase
      e.sel = sel;
      e.exp = code_vec(code);
      e.idx = vec_n;
      vec_n++;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(posedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic check_inv(input string name, input logic [5:0] v);
      // v = {en_ab, en_ba, gnt_a, gnt_b, busy, turn}
      checks++;
      if ((v[5] & v[4]) || (v[1] != (v[5] | v[4] | v[0])) ||
          (v[3] != v[5]) || (v[2] != v[4])) begin
         errors++;
         $display("FAIL inv_%s: outputs %b violate exclusion/busy/grant rules", name, v);
      end
   endtask

   // Monitor: every cycle with a pending expectation, compare just after the edge.
   initial begin
      sb_t        e;
      logic [5:0] g;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            g = got_vec(e.sel);
            checks++;
            if (g !== e.exp) begin
               errors++;
               $display("FAIL vec%0d dut%0d: got %b want %b", e.idx, e.sel, g, e.exp);
            end
         end
      end
   end

   initial begin
      logic       ra, rb;
      logic [5:0] v;
      checks = 0;
      errors = 0;
      vec_n  = 0;
      rst    = 1'b1;
      ifm.req_a = 0; ifm.req_b = 0;
      ifu.req_a = 0; ifu.req_b = 0;
      if1.req_a = 0; if1.req_b = 0;
      if3.req_a = 0; if3.req_b = 0;

      #1;
      checks++;
      if (got_vec(0) !== 6'b0) begin
         errors++;
         $display("FAIL reset_state: got %b want 000000", got_vec(0));
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single requester, voluntary release, two-cycle turnaround, back to idle.
      step(0, 0, 0, C_I);
      step(0, 1, 0, C_A);
      step(0, 1, 0, C_A);
      step(0, 1, 0, C_A);
      step(0, 1, 0, C_A);
      step(0, 0, 0, C_T);
      step(0, 0, 0, C_T);
      step(0, 0, 0, C_I);

      // Asynchronous reset in the middle of an A tenure.
      step(0, 1, 0, C_A);
      step(0, 1, 0, C_A);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (got_vec(0) !== 6'b0) begin
         errors++;
         $display("FAIL async_reset: got %b want 000000 before next edge", got_vec(0));
      end
      ifm.req_a = 0;
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, C_I);
      step(0, 0, 0, C_I);

      // Tie after reset: A first; A releases, B follows after the turnaround.
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_A);
      step(0, 0, 1, C_T);
      step(0, 0, 1, C_T);
      step(0, 0, 1, C_B);
      // B held while A waits: forced off after 4 granted cycles, A takes over.
      step(0, 1, 1, C_B);
      step(0, 1, 1, C_B);
      step(0, 1, 1, C_B);
      step(0, 1, 1, C_T);
      step(0, 1, 1, C_T);
      step(0, 1, 1, C_A);
      // Symmetric: A forced off after 4 cycles, B granted.
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_T);
      step(0, 1, 1, C_T);
      step(0, 1, 1, C_B);
      // Both drop on what would be the forced-release cycle: TURN then IDLE.
      step(0, 1, 1, C_B);
      step(0, 1, 1, C_B);
      step(0, 1, 1, C_B);
      step(0, 0, 0, C_T);
      step(0, 0, 0, C_T);
      step(0, 0, 0, C_I);
      // Preempted A regains the bus because B drops during the turnaround.
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_A);
      step(0, 1, 1, C_T);
      step(0, 1, 0, C_T);
      step(0, 1, 0, C_A);
      // Same-side re-request during TURN still pays the full turnaround.
      step(0, 0, 0, C_T);
      step(0, 1, 0, C_T);
      step(0, 1, 0, C_A);
      step(0, 0, 0, C_T);
      step(0, 0, 0, C_T);
      step(0, 0, 0, C_I);

      // Unlimited hold: A keeps the bus for 100+ cycles despite B waiting.
      step(1, 1, 1, C_A);
      repeat (100) step(1, 1, 1, C_A);
      step(1, 0, 1, C_T);
      step(1, 0, 1, C_T);
      step(1, 0, 1, C_B);
      step(1, 0, 0, C_T);
      step(1, 0, 0, C_T);
      step(1, 0, 0, C_I);

      // TURNAROUND = 1: single dead cycle between owners.
      step(2, 1, 1, C_A);
      step(2, 0, 1, C_T);
      step(2, 0, 1, C_B);
      step(2, 0, 0, C_T);
      step(2, 0, 0, C_I);

      // TURNAROUND = 3: three dead cycles.
      step(3, 1, 0, C_A);
      step(3, 0, 1, C_T);
      step(3, 0, 1, C_T);
      step(3, 0, 1, C_T);
      step(3, 0, 1, C_B);
      step(3, 0, 0, C_T);
      step(3, 0, 0, C_T);
      step(3, 0, 0, C_T);
      step(3, 0, 0, C_I);
      drain();

      // Random requests on the TURNAROUND 1 and 3 instances; sticky requests
      // so tenures and forced releases actually happen.
      ra = 0;
      rb = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) ra = ~ra;
         if ($urandom_range(0, 5) == 0) rb = ~rb;
         if1.req_a = ra; if1.req_b = rb;
         if3.req_a = ra; if3.req_b = rb;
         @(posedge clk);
         #1;
         v = got_vec(2);
         check_inv("t1", v);
         v = got_vec(3);
         check_inv("t3", v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
